// File: rtl/lfsr_share_pkg.sv
// Shared definitions for the LFSR sharing controller.
// Contents: FSM state type, LFSR/output widths, default seed and the
// LFSR next-state function used by lfsr_share_ctrl.
package lfsr_share_pkg;

  localparam int unsigned LFSR_W = 5;
  localparam int unsigned OUT_W  = 4;

  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 5'h1f;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StGap,
    StReload
  } state_e;

  // One LFSR step; every bit is a direct XOR of current-state bits.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] a);
    logic [LFSR_W-1:0] b;
    b[4]   = a[0];
    b[3:2] = a[4:3] ^ a[1:0];
    b[1:0] = a[2:1] ^ a[4:3] ^ a[1:0];
    return b;
  endfunction

endpackage

// File: rtl/lfsr_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after rr_ptr,
// ascending with wrap-around.
// Ports:
//   req        - request vector
//   rr_ptr     - index where the search starts
//   winner_oh  - one-hot winner (all zero when req is zero)
//   winner_idx - index of the winner (0 when req is zero)
module lfsr_share_ctrl_rr_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [NREQ-1:0]  winner_oh,
  output logic [PTR_W-1:0] winner_idx
);

  logic        found;
  int unsigned cand;

  always_comb begin
    winner_oh  = '0;
    winner_idx = '0;
    found      = 1'b0;
    cand       = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = (32'(rr_ptr) + i) % NREQ;
      if (!found && req[cand]) begin
        found           = 1'b1;
        winner_oh[cand] = 1'b1;
        winner_idx      = PTR_W'(cand);
      end
    end
  end

endmodule

// File: rtl/lfsr_share_ctrl.sv
// Shares one 5-bit LFSR between NREQ requesters with round-robin arbitration.
// The LFSR advances exactly once per granted word; seeds can be reloaded at
// run time and a zero seed is replaced by SEED to avoid lock-up.
// Optional feature macro: LFSR_STEP_CNT_EN (saturating LFSR step counter).
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   req        - per-requester request level, held until its grant
//   gnt        - registered one-hot grant pulse (1 cycle)
//   rdata      - random word for the granted requester, held when rvalid=0
//   rvalid     - qualifies rdata, coincident with gnt
//   seed_load  - 1-cycle seed reload request
//   seed_val   - seed captured on seed_load
//   busy       - FSM not idle or reload pending
//   step_cnt   - LFSR step count (0 when the feature is disabled)
module lfsr_share_ctrl
  import lfsr_share_pkg::*;
#(
  parameter int unsigned       NREQ = 4,
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   gnt,
  output logic [OUT_W-1:0]  rdata,
  output logic              rvalid,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_val,
  output logic              busy,
  output logic [15:0]       step_cnt
);

  localparam int unsigned PtrW = $clog2(NREQ);

  state_e              state_q, state_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [LFSR_W-1:0]   seed_q, seed_d;
  logic                pend_q, pend_d;
  logic [PtrW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [OUT_W-1:0]    rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;
  logic [NREQ-1:0]     win_oh;
  logic [PtrW-1:0]     win_idx;

  lfsr_share_ctrl_rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PtrW)
  ) u_arb (
    .req        (req),
    .rr_ptr     (rr_ptr_q),
    .winner_oh  (win_oh),
    .winner_idx (win_idx)
  );

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    rr_ptr_d = rr_ptr_q;
    pend_d   = pend_q | seed_load;
    seed_d   = seed_load ? seed_val : seed_q;
    gnt_d    = '0;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    unique case (state_q)
      StIdle: begin
        // A same-cycle seed_load counts as pending so the reload wins over req.
        if (pend_q || seed_load) begin
          state_d = StReload;
        end else if (|req) begin
          state_d  = StGrant;
          gnt_d    = win_oh;
          rdata_d  = lfsr_q[LFSR_W-1:1];
          rvalid_d = 1'b1;
          lfsr_d   = lfsr_next(lfsr_q);
          rr_ptr_d = (32'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
        end
      end
      StGrant: state_d = StGap;
      StGap:   state_d = StIdle;
      StReload: begin
        lfsr_d  = (seed_q == '0) ? SEED : seed_q;
        pend_d  = seed_load;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      lfsr_q   <= SEED;
      seed_q   <= '0;
      pend_q   <= 1'b0;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      seed_q   <= seed_d;
      pend_q   <= pend_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign gnt    = gnt_q;
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign busy   = (state_q != StIdle) | pend_q;

`ifdef LFSR_STEP_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StReload) begin
      cnt_d = '0;
    end else if (state_q == StIdle && state_d == StGrant && cnt_q != 16'hffff) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign step_cnt = cnt_q;
`else
  assign step_cnt = '0;
`endif

endmodule
